// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC and issues one request at a time to a variable-latency imem.
// Presents {PC, instruction, valid} to IF/ID and holds them under stall; takes redirects from EX.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        res,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] INSTRUCTION_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_reg;
  logic [31:0] fetch_pc_reg;
  logic [31:0] req_pc_reg;
  logic        kill_reg;
  logic [31:0] hold_pc_reg;
  logic [31:0] hold_instr_reg;
  logic [31:0] pc_out_reg;
  logic [31:0] instr_out_reg;
  logic        valid_out_reg;

  logic        accept;
  logic        resp;
  logic        deliver;
  logic [31:0] new_pc;
  logic [31:0] new_instr;
  logic [31:0] target_pc;

  assign accept    = (state_reg == S_REQ) && imem_gnt;
  assign resp      = (state_reg == S_WAIT) && imem_rvalid;
  // A fresh instruction reaches the output register only when IF/ID can take it and no flush is pending.
  assign deliver   = !redirect && !stall && ((resp && !kill_reg) || (state_reg == S_HOLD));
  assign new_pc    = (state_reg == S_HOLD) ? hold_pc_reg : req_pc_reg;
  assign new_instr = (state_reg == S_HOLD) ? hold_instr_reg : imem_rdata;
  assign target_pc = {redirect_pc[31:2], 2'b00};

  assign imem_req        = (state_reg == S_REQ);
  assign imem_addr       = fetch_pc_reg;
  assign PC_out          = pc_out_reg;
  assign INSTRUCTION_out = instr_out_reg;
  assign valid_out       = valid_out_reg;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_reg      <= S_REQ;
      fetch_pc_reg   <= RESET_PC;
      req_pc_reg     <= RESET_PC;
      kill_reg       <= 1'b0;
      hold_pc_reg    <= 32'h0;
      hold_instr_reg <= NOP_INSTR;
      pc_out_reg     <= 32'h0;
      instr_out_reg  <= NOP_INSTR;
      valid_out_reg  <= 1'b0;
    end else begin
      if (redirect) begin
        valid_out_reg <= 1'b0;
        instr_out_reg <= NOP_INSTR;
      end else if (!stall) begin
        if (deliver) begin
          pc_out_reg    <= new_pc;
          instr_out_reg <= new_instr;
          valid_out_reg <= 1'b1;
        end else begin
          valid_out_reg <= 1'b0;
          instr_out_reg <= NOP_INSTR;
        end
      end

      if (redirect) begin
        fetch_pc_reg <= target_pc;
      end else if (accept) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
      end

      if (accept) begin
        req_pc_reg <= fetch_pc_reg;
      end

      case (state_reg)
        S_REQ: begin
          if (imem_gnt) begin
            // A request granted in the redirect cycle is already in flight; its data must be dropped.
            kill_reg  <= redirect;
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (resp) begin
            kill_reg <= 1'b0;
            if (redirect || kill_reg || !stall) begin
              state_reg <= S_REQ;
            end else begin
              hold_pc_reg    <= req_pc_reg;
              hold_instr_reg <= imem_rdata;
              state_reg      <= S_HOLD;
            end
          end else if (redirect) begin
            kill_reg <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect || !stall) begin
            state_reg <= S_REQ;
          end
        end
        default: begin
          state_reg <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: memory model checks request addresses, scoreboard checks presented instructions.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        res;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PC_out;
  logic [31:0] INSTRUCTION_out;
  logic        valid_out;

  if_fetch_unit dut (
    .clk             (clk),
    .res             (res),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .PC_out          (PC_out),
    .INSTRUCTION_out (INSTRUCTION_out),
    .valid_out       (valid_out)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  exp_t        exp_q[$];
  logic [31:0] exp_addr[$];
  pend_t       pend[$];

  int checks   = 0;
  int failures = 0;
  int now      = 0;
  int budget   = 0;
  int lat      = 1;
  int mcyc     = 0;
  bit special4 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (special4 && a == 32'h4) return 32'h00A0_0093;
    return a | 32'h13;
  endfunction

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] ins);
    exp_t e;
    e.pc  = pc;
    e.ins = ins;
    return e;
  endfunction

  // Memory model: grants while budget lasts, answers in order after 'lat' cycles.
  initial begin
    pend_t p;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      mcyc++;
      imem_rvalid = 1'b0;
      if (pend.size() > 0 && pend[0].due <= mcyc) begin
        p = pend.pop_front();
        imem_rvalid = 1'b1;
        imem_rdata  = mem_data(p.addr);
      end
      if (imem_req && budget > 0) begin
        budget--;
        imem_gnt = 1'b1;
        if (exp_addr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant actual=%h required=none", imem_addr);
        end else begin
          chk("req_addr", imem_addr, exp_addr.pop_front());
        end
        p.addr = imem_addr;
        p.due  = mcyc + lat;
        pend.push_back(p);
      end else begin
        imem_gnt = 1'b0;
      end
    end
  end

  // Scoreboard monitor: an instruction leaves the output when consumed or flushed by redirect.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (res && valid_out && (!stall || redirect)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=pc %h instr %h required=none", PC_out, INSTRUCTION_out);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", PC_out, e.pc);
          chk("out_instr", INSTRUCTION_out, e.ins);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic goto(input int k);
    while (now < k) step();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    res         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    budget      = 0;
    lat         = 1;
    pend.delete();
    #1;
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_pc", PC_out, 32'h0);
    chk("rst_instr", INSTRUCTION_out, NOP);
    chk("rst_req", 32'(imem_req), 32'h1);
    chk("rst_addr", imem_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    res = 1'b1;
    now = 0;
  endtask

  initial begin
    res         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Zero-wait streaming: addresses 0,4,8, one instruction every 2nd cycle
    do_reset();
    budget = 3;
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h4);
    exp_addr.push_back(32'h8);
    exp_q.push_back(mk(32'h0, 32'h13));
    exp_q.push_back(mk(32'h4, 32'h17));
    exp_q.push_back(mk(32'h8, 32'h1B));
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("t1_valid_c%0d", k), 32'(valid_out), 32'(k % 2 == 0));
    end
    goto(8);
    $display("t1 stream done: checks=%0d", checks);

    // Stall for 3 cycles while the PC 4 response lands in the hold buffer
    do_reset();
    special4 = 1;
    budget = 2;
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h4);
    exp_q.push_back(mk(32'h0, 32'h13));
    exp_q.push_back(mk(32'h4, 32'h00A0_0093));
    goto(2);
    stall = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      goto(k);
      chk($sformatf("t2_req_c%0d", k), 32'(imem_req), 32'h0);
      chk($sformatf("t2_valid_c%0d", k), 32'(valid_out), 32'h1);
      chk($sformatf("t2_pc_c%0d", k), PC_out, 32'h0);
    end
    stall = 1'b0;
    goto(6);
    chk("t2_valid_after", 32'(valid_out), 32'h1);
    chk("t2_pc_after", PC_out, 32'h4);
    chk("t2_instr_after", INSTRUCTION_out, 32'h00A0_0093);
    goto(8);
    special4 = 0;
    $display("t2 stall/hold done: checks=%0d", checks);

    // Redirect in WAIT ahead of a 3-cycle response for PC 8
    do_reset();
    budget = 4;
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h4);
    exp_addr.push_back(32'h8);
    exp_addr.push_back(32'h100);
    exp_q.push_back(mk(32'h0, 32'h13));
    exp_q.push_back(mk(32'h4, 32'h17));
    exp_q.push_back(mk(32'h100, 32'h113));
    goto(3);
    lat = 3;
    goto(5);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    goto(6);
    redirect = 1'b0;
    lat      = 1;
    chk("t3_req_killed", 32'(imem_req), 32'h0);
    goto(7);
    chk("t3_valid_c7", 32'(valid_out), 32'h0);
    goto(8);
    chk("t3_req_c8", 32'(imem_req), 32'h1);
    chk("t3_addr_c8", imem_addr, 32'h100);
    chk("t3_valid_c8", 32'(valid_out), 32'h0);
    goto(10);
    chk("t3_valid_c10", 32'(valid_out), 32'h1);
    chk("t3_pc_c10", PC_out, 32'h100);
    goto(12);
    $display("t3 redirect-in-wait done: checks=%0d", checks);

    // Redirect together with stall while a buffered instruction is held
    do_reset();
    special4 = 1;
    budget = 3;
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h4);
    exp_addr.push_back(32'h200);
    exp_q.push_back(mk(32'h0, 32'h13));
    exp_q.push_back(mk(32'h200, 32'h213));
    goto(2);
    stall = 1'b1;
    goto(4);
    chk("t4_valid_pre", 32'(valid_out), 32'h1);
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    goto(5);
    chk("t4_valid_flush", 32'(valid_out), 32'h0);
    chk("t4_instr_flush", INSTRUCTION_out, NOP);
    chk("t4_req", 32'(imem_req), 32'h1);
    chk("t4_addr", imem_addr, 32'h200);
    redirect = 1'b0;
    stall    = 1'b0;
    goto(7);
    chk("t4_valid_c7", 32'(valid_out), 32'h1);
    chk("t4_pc_c7", PC_out, 32'h200);
    goto(9);
    special4 = 0;
    $display("t4 redirect+stall done: checks=%0d", checks);

    // Fetch PC wraps past 0xFFFFFFFC
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    goto(1);
    redirect = 1'b0;
    chk("t5_addr_target", imem_addr, 32'hFFFF_FFFC);
    budget = 2;
    exp_addr.push_back(32'hFFFF_FFFC);
    exp_addr.push_back(32'h0);
    exp_q.push_back(mk(32'hFFFF_FFFC, 32'hFFFF_FFFF));
    exp_q.push_back(mk(32'h0, 32'h13));
    goto(3);
    chk("t5_valid_c3", 32'(valid_out), 32'h1);
    chk("t5_pc_c3", PC_out, 32'hFFFF_FFFC);
    goto(6);
    $display("t5 wrap done: checks=%0d", checks);

    // Reset asserted mid-WAIT; the stale response after release is ignored
    do_reset();
    budget = 2;
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h4);
    goto(1);
    lat = 3;
    goto(2);
    stall = 1'b1;
    goto(3);
    chk("t6_valid_c3", 32'(valid_out), 32'h1);
    chk("t6_pc_c3", PC_out, 32'h0);
    chk("t6_req_c3", 32'(imem_req), 32'h0);
    goto(4);
    res = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(valid_out), 32'h0);
    chk("t6_rst_pc", PC_out, 32'h0);
    chk("t6_rst_instr", INSTRUCTION_out, NOP);
    chk("t6_rst_req", 32'(imem_req), 32'h1);
    stall = 1'b0;
    step();
    res = 1'b1;
    goto(6);
    chk("t6_stale_valid", 32'(valid_out), 32'h0);
    chk("t6_stale_req", 32'(imem_req), 32'h1);
    chk("t6_stale_addr", imem_addr, 32'h0);
    lat    = 1;
    budget = 1;
    exp_addr.push_back(32'h0);
    exp_q.push_back(mk(32'h0, 32'h13));
    goto(8);
    chk("t6_valid_c8", 32'(valid_out), 32'h1);
    chk("t6_pc_c8", PC_out, 32'h0);
    goto(10);
    $display("t6 reset mid-wait done: checks=%0d", checks);

    chk("leftover_outputs", 32'(exp_q.size()), 32'h0);
    chk("leftover_addrs", 32'(exp_addr.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage of the 5-stage RISC-V pipeline, directly upstream of the IF/ID pipeline register. It owns the fetch PC and drives a request/grant/response instruction-memory port with variable latency. It presents {PC, instruction, valid} to IF/ID, honours the hazard-unit stall, and takes branch/jump redirects from EX. At most one memory request is outstanding; a one-entry hold buffer absorbs a response that arrives while stalled.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INSTR, 32'h0000_0013, instruction driven when output is invalid (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
res  input  1  asynchronous active-low reset
stall  input  1  hazard unit: IF/ID not accepting; outputs must hold
redirect  input  1  EX: taken branch/jump, flush and refetch
redirect_pc  input  32  target address, valid when redirect=1
imem_req  output  1  memory request valid
imem_addr  output  32  request address, word aligned
imem_gnt  input  1  request accepted this cycle (when imem_req=1)
imem_rvalid  input  1  response data valid
imem_rdata  input  32  response instruction word
PC_out  output  32  PC of presented instruction (registered)
INSTRUCTION_out  output  32  presented instruction (registered)
valid_out  output  1  PC_out/INSTRUCTION_out hold a real instruction

Behaviour:
- Reset (res=0, async): fetch_pc=RESET_PC, state=REQ, kill=0, buffer empty, PC_out=0, INSTRUCTION_out=NOP_INSTR, valid_out=0.
- Memory protocol: a request is accepted in a cycle with imem_req&imem_gnt. imem_addr is stable while imem_req=1 and ungranted. The response arrives in order, at least 1 cycle after acceptance. imem_rvalid with nothing outstanding is ignored.
- States:
  - REQ: imem_req=1, imem_addr=fetch_pc. On gnt: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32, wraps), go WAIT.
  - WAIT: imem_req=0. On rvalid:
    - kill=1: drop the data, kill<=0, go REQ.
    - stall=0: PC_out<=req_pc, INSTRUCTION_out<=imem_rdata, valid_out<=1, go REQ.
    - stall=1: buffer<={req_pc,imem_rdata}, go HOLD.
  - HOLD: imem_req=0. When stall=0, move the buffer to the outputs with valid_out=1 and go REQ.
- Output register:
  - stall=1: all outputs hold.
  - stall=0 and no new instruction this cycle: valid_out<=0, INSTRUCTION_out<=NOP_INSTR, PC_out holds.
  - A presented instruction is consumed in any cycle it is valid and stall=0.
- Throughput: with zero-wait memory (gnt same cycle, rvalid next cycle), at most one instruction every 2 cycles. First valid_out no earlier than cycle 2 after reset release.
- Redirect (priority over stall and over all state actions):
  - fetch_pc<=redirect_pc, buffer discarded, valid_out<=0, INSTRUCTION_out<=NOP_INSTR.
  - In REQ without gnt: next state REQ. The new address is driven next cycle; the old request is withdrawn.
  - In REQ with gnt that cycle: that request is outstanding, so kill<=1 and go WAIT.
  - In WAIT without rvalid that cycle: kill<=1 and stay WAIT.
  - In WAIT with rvalid that cycle: drop the data and go REQ.
  - In HOLD: go REQ.
  - Redirect and stall together: redirect wins; outputs are flushed.
- redirect_pc[1:0] are forced to 0 on use. Misaligned-target exceptions are not handled here.
- Reset mid-operation: all state returns to reset values. An in-flight memory response arriving after reset release with nothing outstanding is ignored.

Test Plan:
- Reset then zero-wait memory returning rdata=addr|0x13. Required: imem_addr sequence 0,4,8. valid_out pulses with PC_out 0,4,8 and INSTRUCTION_out 0x13,0x17,0x1B, every 2nd cycle.
- stall=1 held 3 cycles while the response for PC 4 (0x00A00093) arrives. Required: outputs hold PC 0 the whole time and imem_req stays 0. The cycle after stall drops, PC_out=4 and INSTRUCTION_out=0x00A00093 with valid_out=1.
- redirect=1, redirect_pc=0x100 in WAIT, before a 3-cycle-latency response for PC 8. Required: the PC 8 data is never presented. The next request has imem_addr=0x100 and the next valid output has PC_out=0x100.
- redirect=1 together with stall=1 while holding a buffered instruction. Required: next cycle valid_out=0 and INSTRUCTION_out=0x00000013. The buffer is dropped and the fetch restarts at the target.
- fetch_pc=0xFFFFFFFC granted. Required: next request address 0x00000000 (wrap).
- Assert res mid-WAIT. Required: outputs immediately 0/NOP/0, the stale rvalid after release is ignored, and the first request is at RESET_PC.
